wavefront_mask_sequencer: RTL
=============================

// Module: wavefront_mask_sequencer
// PURPOSE
//   Control stage directly upstream of dual_shift_register. Turns a one-shot start into the
//   shift/shift_in/direction_right/reset_zero sequence: clear, fill sweep right, drain sweep left.
//   Drives the lane-enable mask for the LCMV systolic array, one lane per step.
//   Steps are paced by the array through step_en. Reports busy/done to the top-level controller.
// PARAMETERS
//   WIDTH  5  number of lanes = mask width; legal range WIDTH >= 2
//   CW     $clog2(WIDTH)  derived, not overridable; width of step_idx
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      begin a sequence; sampled only in IDLE
//   mode       in   1      0 = FILL (thermometer), 1 = WALK (single walking one); latched at start
//   step_en    in   1      array ready for next mask step; sampled only in FILL/DRAIN
//   mask       out  WIDTH  lane-enable mask (registered, output of dual_shift_register)
//   mask_valid out  1      high the cycle after each accepted step (mask just changed)
//   step_idx   out  CW     accepted steps so far in current sweep, 0..WIDTH-1
//   sweep_right out 1      1 during FILL sweep, 0 otherwise
//   busy       out  1      state != IDLE
//   done       out  1      one-cycle pulse, state == DONE
// BEHAVIOUR
//   Reset: state=IDLE, mask=0, mask_valid=0, step_idx=0, sweep_right=0, busy=0, done=0, mode_q=0.
//   rst wins over everything, including mid-sequence: all regs to reset values next edge.
//   States (enum in package): IDLE -> CLEAR -> FILL -> DRAIN -> DONE -> IDLE.
//   IDLE:  start=1 -> latch mode_q, go CLEAR. start=0 -> stay. step_en ignored.
//   CLEAR: exactly 1 cycle. reset_zero=1, shift=0 to sub-module (mask<=0). step_en ignored. -> FILL.
//   FILL:  step_en=1 -> shift=1, direction_right=1; mask <= {shift_in, mask[WIDTH-1:1]}.
//          shift_in = 1 if mode_q=FILL; if mode_q=WALK, shift_in = (step_idx==0).
//          step_idx==WIDTH-1 on accepted step -> step_idx<=0, go DRAIN; else step_idx++.
//          step_en=0 -> stall: mask, step_idx hold, no shift.
//   DRAIN: step_en=1 -> shift=1, direction_right=0, shift_in=0; mask <= {mask[WIDTH-2:0],1'b0}.
//          step_idx==WIDTH-1 on accepted step -> step_idx<=0, go DONE; else step_idx++. Stall as FILL.
//   DONE:  1 cycle, done=1, busy=1, mask==0 guaranteed. -> IDLE. start here is ignored (not queued).
//   start while busy: ignored. mode changes after latch: no effect until next start.
//   sub-module controls are single-source; reset_zero and shift never both 1.
//   mask_valid: registered copy of (shift accepted); 0 during CLEAR, stalls, DONE.
//   Timing: start sampled at edge t -> CLEAR after t; mask=0 after t+1; first step accepted
//     earliest at t+2. With step_en tied 1: done high in the cycle after edge t+1+2*WIDTH
//     (2*WIDTH+2 cycles start-to-done).
//   FILL, WIDTH=5, step_en=1: mask after steps 1..5 = 10000,11000,11100,11110,11111;
//     DRAIN then 11110,11100,11000,10000,00000.
//   WALK: FILL gives 10000,01000,00100,00010,00001; DRAIN gives 00010,00100,01000,10000,00000.
// STRUCTURE
//   Package mask_seq_pkg: typedef enum logic [2:0] seq_state_t {IDLE,CLEAR,FILL,DRAIN,DONE};
//     typedef enum logic {MODE_FILL, MODE_WALK} seq_mode_t.
//   One sub-module: dual_shift_register #(.WIDTH(WIDTH)) holds mask. This block owns FSM, step counter,
//     mask_valid/done registers and the combinational control decode.
// TESTING
//   1 WIDTH=5, rst 3 cycles, start 1 cycle, mode=FILL, step_en=1 -> mask 10000..11111 then 11110..00000;
//     done pulses once, 12 cycles after start sampled; busy low afterwards.
//   2 mode=WALK, step_en=1 -> mask 10000,01000,00100,00010,00001,00010,00100,01000,10000,00000.
//   3 FILL with step_en toggled 1,0,0,1,... -> mask/step_idx frozen on 0 cycles, mask_valid only after
//     accepted steps; final sequence identical to test 1.
//   4 start pulsed during FILL and in DONE cycle -> ignored; no second sequence, exactly one done.
//   5 rst asserted in DRAIN with mask=11100 -> next cycle mask=0, busy=0, step_idx=0, no done pulse;
//     new start then runs full sequence.
//   6 mask preloaded nonzero by an aborted run, then start -> CLEAR zeroes mask before the first step;
//     first step gives 10000.

Source files
------------

// File: rtl/mask_seq_pkg.sv
// Shared state and mode encodings for the wavefront mask sequencer.
package mask_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FILL,
    DRAIN,
    DONE
  } seq_state_t;

  typedef enum logic {
    MODE_FILL,
    MODE_WALK
  } seq_mode_t;

endpackage

// File: rtl/dual_shift_register.sv
// Bidirectional mask register: synchronous clear, or one-bit shift in either direction.
module dual_shift_register #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             shift_in,
  input  logic             direction_right,
  input  logic             reset_zero,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (reset_zero) begin
      q <= '0;
    end else if (shift) begin
      if (direction_right) begin
        q <= {shift_in, q[WIDTH-1:1]};
      end else begin
        q <= {q[WIDTH-2:0], shift_in};
      end
    end
  end

endmodule

// File: rtl/wavefront_mask_sequencer.sv
// Sequences clear / right fill sweep / left drain sweep of the lane-enable mask,
// one lane per accepted step_en, and reports busy/done upstream.
module wavefront_mask_sequencer
  import mask_seq_pkg::*;
#(
  parameter  int WIDTH = 5,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             step_en,
  output logic [WIDTH-1:0] mask,
  output logic             mask_valid,
  output logic [CW-1:0]    step_idx,
  output logic             sweep_right,
  output logic             busy,
  output logic             done
);

  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  seq_state_t    state;
  seq_state_t    state_next;
  seq_mode_t     mode_q;
  logic [CW-1:0] step_next;
  logic          shift;
  logic          shift_in;
  logic          direction_right;
  logic          reset_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= MODE_FILL;
      step_idx   <= '0;
      mask_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      step_idx   <= step_next;
      mask_valid <= shift;
      done       <= (state_next == DONE);
      if (state == IDLE && start) begin
        mode_q <= seq_mode_t'(mode);
      end
    end
  end

  always_comb begin
    state_next      = state;
    step_next       = step_idx;
    shift           = 1'b0;
    shift_in        = 1'b0;
    direction_right = 1'b0;
    reset_zero      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        reset_zero = 1'b1;
        state_next = FILL;
      end
      FILL: begin
        if (step_en) begin
          shift           = 1'b1;
          direction_right = 1'b1;
          // Walk mode injects a single one on the first step only.
          shift_in        = (mode_q == MODE_FILL) ? 1'b1 : (step_idx == '0);
          if (step_idx == LAST_STEP) begin
            step_next  = '0;
            state_next = DRAIN;
          end else begin
            step_next = step_idx + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (step_en) begin
          shift = 1'b1;
          if (step_idx == LAST_STEP) begin
            step_next  = '0;
            state_next = DONE;
          end else begin
            step_next = step_idx + 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy        = (state != IDLE);
  assign sweep_right = (state == FILL);

  dual_shift_register #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk            (clk),
    .rst            (rst),
    .shift          (shift),
    .shift_in       (shift_in),
    .direction_right(direction_right),
    .reset_zero     (reset_zero),
    .q              (mask)
  );

endmodule
